// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NREQ requesters with a one-deep tagged response register.
// Round-robin by default; define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins with no pointer flops.
module alu_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 3
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [4*NREQ-1:0]   req_op,
  input  logic [32*NREQ-1:0]  req_a,
  input  logic [32*NREQ-1:0]  req_b,
  output logic [3:0]          aluop,
  output logic [31:0]         portA,
  output logic [31:0]         portB,
  input  logic [31:0]         portOut,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [31:0]         rsp_data,
  input  logic                rsp_ready
);
  localparam logic [3:0] ALU_ADD = 4'd3;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  logic [31:0]    r_data;
  logic [IDW-1:0] w_base;
  logic [IDW-1:0] w_gid;
  logic           w_free;
  logic           w_hit;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [IDW-1:0] r_ptr;
  assign w_base = r_ptr;
  always_ff @(posedge CLK or posedge nRST)
    if (nRST) r_ptr <= '0;
    else if (w_hit) r_ptr <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
`endif
  assign w_free = !r_valid || rsp_ready;
  // scan from the pointer, wrapping once past NREQ-1
  always_comb begin
    int j;
    j = 0;
    w_hit = 1'b0;
    w_gid = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(w_base) + k;
      if (j >= NREQ) j = j - NREQ;
      if (w_free && !w_hit && |(req_valid & (NREQ'(1) << j))) begin
        w_hit = 1'b1;
        w_gid = IDW'(j);
      end
    end
  end
  assign req_ready = w_hit ? NREQ'(1) << w_gid : '0;
  assign aluop     = w_hit ? 4'(req_op >> (4 * w_gid)) : ALU_ADD;
  assign portA     = w_hit ? 32'(req_a >> (32 * w_gid)) : '0;
  assign portB     = w_hit ? 32'(req_b >> (32 * w_gid)) : '0;
  always_ff @(posedge CLK or posedge nRST)
    if (nRST) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_data  <= '0;
    end else if (w_hit) begin
      r_valid <= 1'b1;
      r_id    <= w_gid;
      r_data  <= portOut;
    end else if (rsp_ready) begin
      r_valid <= 1'b0;
    end
  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus randomized traffic against a queue-free behavioural model.
module tb_alu_arbiter;
  localparam int NREQ = 3;
  localparam int IDW  = 3;
  localparam logic [3:0] SLL = 4'd0, SRL = 4'd1, SRA = 4'd2, ADD = 4'd3, SUB = 4'd4, AND_ = 4'd5,
                         OR_ = 4'd6, XOR_ = 4'd7, NOR_ = 4'd8, SLT = 4'd9, SLTU = 4'd10;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic                CLK = 1'b0;
  logic                nRST = 1'b1;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [4*NREQ-1:0]   req_op;
  logic [32*NREQ-1:0]  req_a, req_b;
  logic [3:0]          aluop;
  logic [31:0]         portA, portB, portOut, rsp_data;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  int errors = 0;
  int checks = 0;
  logic [NREQ-1:0] t_v;
  logic [3:0]      t_op [NREQ];
  logic [31:0]     t_a [NREQ];
  logic [31:0]     t_b [NREQ];
  logic            t_rr;
  bit              m_valid;
  int              m_id, m_ptr;
  logic [31:0]     m_data;
  typedef struct {
    logic [NREQ-1:0] v;
    logic [3:0]      op;
    logic [31:0]     a, b;
    logic            rr;
    logic [NREQ-1:0] e_rdy;
    logic            e_rv;
    logic [IDW-1:0]  e_id;
    logic [31:0]     e_data;
  } vec_t;
  vec_t tv[$];

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .aluop(aluop), .portA(portA), .portB(portB), .portOut(portOut),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      SLL:     return a << b[4:0];
      SRL:     return a >> b[4:0];
      SRA:     return $signed(a) >>> b[4:0];
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      NOR_:    return ~(a | b);
      SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign portOut = alu(aluop, portA, portB);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_op[4*i +: 4]  = t_op[i];
      req_a[32*i +: 32] = t_a[i];
      req_b[32*i +: 32] = t_b[i];
    end
    req_valid = t_v;
    rsp_ready = t_rr;
  endtask

  task automatic set_all(input logic [NREQ-1:0] v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rr);
    t_v = v;
    t_rr = rr;
    for (int i = 0; i < NREQ; i++) begin
      t_op[i] = op;
      t_a[i]  = a;
      t_b[i]  = b;
    end
  endtask

  function automatic int model_grant();
    int start;
    if (m_valid && !t_rr) return -1;
    start = FIXED ? 0 : m_ptr;
    for (int k = 0; k < NREQ; k++)
      if (t_v[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_id = 0;
    m_ptr = 0;
    m_data = 0;
  endtask

  // one clock: check combinational outputs mid-cycle, then advance the model past the edge
  task automatic tick(output logic [NREQ-1:0] rdy);
    int g;
    logic [NREQ-1:0] e_rdy;
    logic [3:0] e_op;
    logic [31:0] e_a, e_b;
    drive();
    @(negedge CLK);
    g = model_grant();
    if (g < 0) begin
      e_rdy = '0; e_op = ADD; e_a = 0; e_b = 0;
    end else begin
      e_rdy = NREQ'(1) << g; e_op = t_op[g]; e_a = t_a[g]; e_b = t_b[g];
    end
    rdy = req_ready;
    chk("req_ready", req_ready, e_rdy);
    chk("aluop", aluop, e_op);
    chk("portA", portA, e_a);
    chk("portB", portB, e_b);
    chk("rsp_valid", rsp_valid, m_valid);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_data", rsp_data, m_data);
    @(posedge CLK);
    #1;
    if (g >= 0) begin
      m_valid = 1;
      m_id = g;
      m_data = alu(t_op[g], t_a[g], t_b[g]);
      m_ptr = (g + 1) % NREQ;
    end else if (m_valid && t_rr) begin
      m_valid = 0;
    end
  endtask

  task automatic add(input logic [NREQ-1:0] v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic rr, input logic [NREQ-1:0] er, input logic ev, input logic [IDW-1:0] ei,
                     input logic [31:0] ed);
    vec_t r;
    r.v = v; r.op = op; r.a = a; r.b = b; r.rr = rr;
    r.e_rdy = er; r.e_rv = ev; r.e_id = ei; r.e_data = ed;
    tv.push_back(r);
  endtask

  initial begin
    logic [NREQ-1:0] rdy;
    add(3'b010, ADD, 3, 4, 1, 3'b010, 1, 1, 7);
    add(3'b000, ADD, 0, 0, 1, 3'b000, 0, 1, 7);
    add(3'b001, SLT, 32'hFFFFFFFF, 1, 1, 3'b001, 1, 0, 1);
    add(3'b100, SLTU, 32'hFFFFFFFF, 1, 1, 3'b100, 1, 2, 0);
    for (int n = 0; n < 6; n++)
      add(3'b111, ADD, 5, 6, 1, FIXED ? 3'b001 : 3'(1 << (n % 3)), 1, FIXED ? 3'd0 : 3'(n % 3), 11);
    for (int n = 0; n < 3; n++)
      add(3'b100, SUB, 10, 12, 0, 3'b000, 1, FIXED ? 3'd0 : 3'd2, 11);
    add(3'b100, SUB, 10, 12, 1, 3'b100, 1, 2, 32'hFFFFFFFE);
    add(3'b000, ADD, 0, 0, 1, 3'b000, 0, 2, 32'hFFFFFFFE);
    add(3'b010, ADD, 1, 1, 1, 3'b010, 1, 1, 2);

    set_all('0, ADD, 0, 0, 0);
    drive();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    nRST = 1'b0;

    foreach (tv[n]) begin
      set_all(tv[n].v, tv[n].op, tv[n].a, tv[n].b, tv[n].rr);
      tick(rdy);
      chk($sformatf("tv%0d_ready", n), rdy, tv[n].e_rdy);
      chk($sformatf("tv%0d_rsp_valid", n), rsp_valid, tv[n].e_rv);
      chk($sformatf("tv%0d_rsp_id", n), rsp_id, tv[n].e_id);
      chk($sformatf("tv%0d_rsp_data", n), rsp_data, tv[n].e_data);
    end

    set_all(3'b001, XOR_, 32'h0F0F, 32'h00FF, 0);
    tick(rdy);
    set_all('0, ADD, 0, 0, 0);
    drive();
    @(negedge CLK);
    chk("pre_rst_valid", rsp_valid, 1);
    nRST = 1'b1;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_rsp_id", rsp_id, 0);
    chk("midrst_aluop", aluop, ADD);
    chk("midrst_portA", portA, 0);
    chk("midrst_portB", portB, 0);
    chk("midrst_ready", req_ready, 0);
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    set_all(3'b111, ADD, 2, 2, 1);
    tick(rdy);
    chk("rst_ptr_grant", rdy, 3'b001);
    chk("rst_ptr_id", rsp_id, 0);

    for (int n = 0; n < 400; n++) begin
      t_v = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      t_rr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        t_op[i] = 4'($urandom_range(0, 10));
        t_a[i] = $urandom;
        t_b[i] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      end
      tick(rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
